// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one pipelined divider among NUM_REQ requesters,
// routing results back through a tag pipe. Optional counters: define DIV_SHARE_STATS_EN.
module div_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN0_LEN   = 8,
  parameter int IN1_LEN   = 8,
  parameter int OUT_LEN   = 8,
  parameter     IS_SIGNED = "true"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*IN0_LEN-1:0]   req_dividend,
  input  logic [NUM_REQ*IN1_LEN-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [OUT_LEN-1:0]           rsp_quot,
  output logic [OUT_LEN-1:0]           rsp_remd,
  output logic                         rsp_div_zero,
  output logic                         busy,
  output logic                         div_ce,
  output logic [IN0_LEN-1:0]           div_dividend,
  output logic [IN1_LEN-1:0]           div_divisor,
  output logic                         div_in_valid,
  input  logic [OUT_LEN-1:0]           div_quot,
  input  logic [OUT_LEN-1:0]           div_remd,
  input  logic                         div_out_valid,
  input  logic                         div_by_zero
`ifdef DIV_SHARE_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [15:0]                  stat_issued,
  output logic [15:0]                  stat_stall,
  output logic [15:0]                  stat_zero
`endif
);

  localparam int L   = OUT_LEN + 2;
  localparam int IdW = $clog2(NUM_REQ);

  logic [L-1:0]   tagVld_q;
  logic [IdW-1:0] tagId_q [L];
  logic [IdW-1:0] rrPtr_q, rrPtr_d;
  logic [IdW-1:0] grantId;
  logic [IdW-1:0] headId;
  logic           headVld;
  logic           grantFound;
  logic           issue;

  assign headVld = tagVld_q[L-1];
  assign headId  = tagId_q[L-1];

  // A result waiting on a requester that is not ready freezes the divider and the tag pipe together.
  assign div_ce = !(headVld && !rsp_ready[headId]);
  assign issue  = grantFound && div_ce && rst_n;
  assign busy   = |tagVld_q;

  always_comb begin
    int idx;
    grantId    = '0;
    grantFound = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rrPtr_q) + k) % NUM_REQ;
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantId    = IdW'(idx);
      end
    end
  end

  always_comb begin
    rrPtr_d      = rrPtr_q;
    req_ready    = '0;
    div_in_valid = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    if (issue) begin
      rrPtr_d      = (grantId == IdW'(NUM_REQ - 1)) ? '0 : grantId + IdW'(1);
      req_ready    = NUM_REQ'(1) << grantId;
      div_in_valid = 1'b1;
      div_dividend = req_dividend[grantId*IN0_LEN +: IN0_LEN];
      div_divisor  = req_divisor[grantId*IN1_LEN +: IN1_LEN];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = headVld && (headId == IdW'(i));
    end
  end

  assign rsp_quot     = div_quot;
  assign rsp_remd     = div_remd;
  assign rsp_div_zero = div_by_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagVld_q <= '0;
      rrPtr_q  <= '0;
      for (int k = 0; k < L; k++) tagId_q[k] <= '0;
    end else if (div_ce) begin
      tagVld_q   <= {tagVld_q[L-2:0], issue};
      tagId_q[0] <= grantId;
      for (int k = 1; k < L; k++) tagId_q[k] <= tagId_q[k-1];
      rrPtr_q    <= rrPtr_d;
    end
  end

  // The tag head must track the divider's own valid; a mismatch means the divider latency is not L.
  assert property (@(posedge clk) disable iff (!rst_n) div_ce |-> (headVld == div_out_valid));

`ifdef DIV_SHARE_STATS_EN
  logic [15:0] statIssued_q, statStall_q, statZero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statIssued_q <= '0;
      statStall_q  <= '0;
      statZero_q   <= '0;
    end else if (stat_clr) begin
      statIssued_q <= '0;
      statStall_q  <= '0;
      statZero_q   <= '0;
    end else begin
      if (issue && statIssued_q != 16'hFFFF) statIssued_q <= statIssued_q + 16'd1;
      if (!div_ce && statStall_q != 16'hFFFF) statStall_q <= statStall_q + 16'd1;
      if (headVld && div_ce && div_by_zero && statZero_q != 16'hFFFF)
        statZero_q <= statZero_q + 16'd1;
    end
  end

  assign stat_issued = statIssued_q;
  assign stat_stall  = statStall_q;
  assign stat_zero   = statZero_q;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: behavioural divider stub plus a queue-based reference model of
// issue order, latency and result routing. Stats ports checked when DIV_SHARE_STATS_EN is defined.
module tb_div_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IN0_LEN = 8;
  localparam int IN1_LEN = 8;
  localparam int OUT_LEN = 8;
  localparam int L       = OUT_LEN + 2;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*IN0_LEN-1:0] req_dividend = '0;
  logic [NUM_REQ*IN1_LEN-1:0] req_divisor = '0;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready = '1;
  logic [OUT_LEN-1:0]         rsp_quot, rsp_remd;
  logic                       rsp_div_zero, busy, div_ce;
  logic [IN0_LEN-1:0]         div_dividend;
  logic [IN1_LEN-1:0]         div_divisor;
  logic                       div_in_valid;
  logic [OUT_LEN-1:0]         div_quot, div_remd;
  logic                       div_out_valid, div_by_zero;
  logic                       stat_clr = 1'b0;
`ifdef DIV_SHARE_STATS_EN
  logic [15:0]                stat_issued, stat_stall, stat_zero;
`endif

  div_share_arbiter #(
    .NUM_REQ(NUM_REQ), .IN0_LEN(IN0_LEN), .IN1_LEN(IN1_LEN), .OUT_LEN(OUT_LEN), .IS_SIGNED("true")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot), .rsp_remd(rsp_remd), .rsp_div_zero(rsp_div_zero),
    .busy(busy), .div_ce(div_ce),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_in_valid(div_in_valid),
    .div_quot(div_quot), .div_remd(div_remd), .div_out_valid(div_out_valid), .div_by_zero(div_by_zero)
`ifdef DIV_SHARE_STATS_EN
    , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_stall(stat_stall), .stat_zero(stat_zero)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the real divider: L enabled stages, signed truncating divide, zero-divisor flag.
  logic [L-1:0]       stubVld;
  logic [OUT_LEN-1:0] stubQ [L];
  logic [OUT_LEN-1:0] stubR [L];
  logic [L-1:0]       stubZ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stubVld <= '0;
      stubZ   <= '0;
      for (int k = 0; k < L; k++) begin
        stubQ[k] <= '0;
        stubR[k] <= '0;
      end
    end else if (div_ce) begin
      stubVld <= {stubVld[L-2:0], div_in_valid};
      stubZ   <= {stubZ[L-2:0], div_in_valid && (div_divisor == '0)};
      if (div_in_valid && div_divisor != '0) begin
        stubQ[0] <= OUT_LEN'(int'($signed(div_dividend)) / int'($signed(div_divisor)));
        stubR[0] <= OUT_LEN'(int'($signed(div_dividend)) % int'($signed(div_divisor)));
      end else begin
        stubQ[0] <= '0;
        stubR[0] <= '0;
      end
      for (int k = 1; k < L; k++) begin
        stubQ[k] <= stubQ[k-1];
        stubR[k] <= stubR[k-1];
      end
    end
  end

  assign div_out_valid = stubVld[L-1];
  assign div_quot      = stubQ[L-1];
  assign div_remd      = stubR[L-1];
  assign div_by_zero   = stubZ[L-1];

  typedef struct {
    int                 id;
    int                 t;
    logic [OUT_LEN-1:0] q;
    logic [OUT_LEN-1:0] r;
    logic               z;
  } opRec_t;

  opRec_t inflight [$];
  int rrModel = 0;
  int enCount = 0;
  int expIssued = 0, expStallCnt = 0, expZero = 0;
  int checks = 0, errors = 0;

  logic [NUM_REQ-1:0]         nxtValid = '0;
  logic [NUM_REQ*IN0_LEN-1:0] nxtDividend = '0;
  logic [NUM_REQ*IN1_LEN-1:0] nxtDivisor = '0;
  logic [NUM_REQ-1:0]         nxtRspReady = '1;
  logic                       nxtStatClr = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void refDiv(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r, output logic z);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '0; r = '0; z = 1'b1;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb); z = 1'b0;
    end
  endfunction

  // Per-cycle comparison against the model, then advance the model across the coming edge.
  task automatic compareModel();
    bit     headPresent, expStall, expIssue;
    int     hid, g, idx;
    opRec_t op;
    headPresent = (inflight.size() > 0) && (enCount - inflight[0].t == L);
    hid         = headPresent ? inflight[0].id : 0;
    expStall    = headPresent && !rsp_ready[hid];
    checkOutput("divCe", div_ce, !expStall);
    checkOutput("rspValid", rsp_valid, headPresent ? (32'd1 << hid) : 32'd0);
    if (headPresent) begin
      checkOutput("rspQuot", rsp_quot, inflight[0].q);
      checkOutput("rspRemd", rsp_remd, inflight[0].r);
      checkOutput("rspDivZero", rsp_div_zero, inflight[0].z);
    end
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (rrModel + k) % NUM_REQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    expIssue = (g >= 0) && !expStall;
    checkOutput("reqReady", req_ready, expIssue ? (32'd1 << g) : 32'd0);
    checkOutput("divInValid", div_in_valid, expIssue);
    checkOutput("divDividend", div_dividend, expIssue ? req_dividend[g*IN0_LEN +: IN0_LEN] : 8'd0);
    checkOutput("divDivisor", div_divisor, expIssue ? req_divisor[g*IN1_LEN +: IN1_LEN] : 8'd0);
    checkOutput("busy", busy, inflight.size() > 0);
    if (div_ce) checkOutput("headAlign", |rsp_valid, div_out_valid);
`ifdef DIV_SHARE_STATS_EN
    checkOutput("statIssued", stat_issued, expIssued);
    checkOutput("statStall", stat_stall, expStallCnt);
    checkOutput("statZero", stat_zero, expZero);
`endif
    if (!expStall) begin
      if (headPresent) begin
        if (inflight[0].z && expZero < 65535) expZero++;
        void'(inflight.pop_front());
      end
      if (expIssue) begin
        op.id = g;
        op.t  = enCount;
        refDiv(req_dividend[g*IN0_LEN +: IN0_LEN], req_divisor[g*IN1_LEN +: IN1_LEN], op.q, op.r, op.z);
        inflight.push_back(op);
        rrModel = (g + 1) % NUM_REQ;
        if (expIssued < 65535) expIssued++;
      end
      enCount++;
    end else if (expStallCnt < 65535) begin
      expStallCnt++;
    end
    if (stat_clr) begin
      expIssued = 0; expStallCnt = 0; expZero = 0;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    req_valid    = nxtValid;
    req_dividend = nxtDividend;
    req_divisor  = nxtDivisor;
    rsp_ready    = nxtRspReady;
    stat_clr     = nxtStatClr;
    @(negedge clk);
    compareModel();
  endtask

  task automatic idle(input int n);
    nxtValid    = '0;
    nxtRspReady = '1;
    repeat (n) applyStimulus();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    stat_clr  = 1'b0;
    @(negedge clk);
    checkOutput("rstReqReady", req_ready, 0);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDivInValid", div_in_valid, 0);
    checkOutput("rstDivCe", div_ce, 1);
`ifdef DIV_SHARE_STATS_EN
    checkOutput("rstStats", {stat_issued, stat_stall | stat_zero}, 0);
`endif
    inflight.delete();
    rrModel = 0; enCount = 0;
    expIssued = 0; expStallCnt = 0; expZero = 0;
    repeat (2) @(negedge clk);
    req_valid   = '0;
    nxtValid    = '0;
    nxtRspReady = '1;
    nxtStatClr  = 1'b0;
    rst_n       = 1'b1;
  endtask

  task automatic directedOp(input int id, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic ez);
    bit found;
    nxtValid                = NUM_REQ'(1) << id;
    nxtDividend[id*8 +: 8]  = a;
    nxtDivisor[id*8 +: 8]   = b;
    nxtRspReady             = '1;
    applyStimulus();
    checkOutput("issueReady", req_ready, 32'd1 << id);
    nxtValid = '0;
    found    = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      applyStimulus();
      if (rsp_valid[id]) begin
        found = 1'b1;
        checkOutput("rspLatency", c, L);
        checkOutput("dirQuot", rsp_quot, eq);
        checkOutput("dirRemd", rsp_remd, er);
        checkOutput("dirDivZero", rsp_div_zero, ez);
      end
    end
    checkOutput("rspSeen", found, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  saw;
    logic [7:0] d;
    doReset();

    // Full contention from a fresh pointer: strict rotation, responses back in issue order.
    nxtRspReady = '1;
    nxtValid    = '1;
    for (int r = 0; r < NUM_REQ; r++) begin
      nxtDividend[r*8 +: 8] = 8'($urandom_range(0, 127));
      nxtDivisor[r*8 +: 8]  = 8'($urandom_range(1, 127));
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      checkOutput("burstGrant", req_ready, 32'd1 << (k % NUM_REQ));
    end
    nxtValid = '0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (rsp_valid != '0) begin
        checkOutput("burstRspOrder", rsp_valid, 32'd1 << (n % NUM_REQ));
        n++;
      end
    end
    checkOutput("burstRspCount", n, 8);

    directedOp(0, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0);
    directedOp(1, 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0);
    directedOp(2, 8'd5, 8'd0, 8'h00, 8'h00, 1'b1);
    idle(2);
`ifdef DIV_SHARE_STATS_EN
    checkOutput("statZeroDirected", stat_zero, 1);
`endif

    // Requester 3 withholds rsp_ready for five cycles while requester 0 is waiting to issue.
    nxtValid           = 4'b1000;
    nxtDividend[31:24] = 8'd50;
    nxtDivisor[31:24]  = 8'd3;
    nxtRspReady        = 4'b0111;
    applyStimulus();
    checkOutput("stallIssue", req_ready, 4'b1000);
    nxtValid = '0;
    repeat (L - 1) applyStimulus();
    nxtValid         = 4'b0001;
    nxtDividend[7:0] = 8'd9;
    nxtDivisor[7:0]  = 8'd4;
    for (int s = 0; s < 5; s++) begin
      applyStimulus();
      checkOutput("stallRspValid", rsp_valid, 4'b1000);
      checkOutput("stallCe", div_ce, 0);
      checkOutput("stallReady", req_ready, 0);
      checkOutput("stallQuot", rsp_quot, 8'h10);
      checkOutput("stallRemd", rsp_remd, 8'h02);
    end
    nxtRspReady = '1;
    applyStimulus();
    checkOutput("releaseReady", req_ready, 4'b0001);
    checkOutput("releaseRsp", rsp_valid, 4'b1000);
    idle(12);
`ifdef DIV_SHARE_STATS_EN
    checkOutput("statStallDirected", stat_stall, 5);
`endif
    nxtStatClr = 1'b1;
    applyStimulus();
    nxtStatClr = 1'b0;
    applyStimulus();

    // Random traffic with random backpressure, zero divisors and occasional counter clears.
    for (int i = 0; i < 250; i++) begin
      nxtValid = NUM_REQ'($urandom);
      for (int r = 0; r < NUM_REQ; r++) begin
        d = 8'($urandom);
        if (d == 8'h80) d = 8'h7F;
        nxtDividend[r*8 +: 8] = d;
        nxtDivisor[r*8 +: 8]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        nxtRspReady[r]        = ($urandom_range(0, 3) != 0);
      end
      nxtStatClr = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end
    nxtStatClr = 1'b0;
    idle(30);

    // Six ops in flight, then reset: nothing may come back afterwards.
    nxtValid = '1;
    repeat (6) applyStimulus();
    checkOutput("busyBeforeReset", busy, 1);
    doReset();
    saw = 1'b0;
    for (int c = 0; c < 15; c++) begin
      applyStimulus();
      if (rsp_valid != '0) saw = 1'b1;
    end
    checkOutput("staleRsp", saw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
